// File: rtl/my_pkg.sv
// Shared control-bundle types, opcode constants and bubble values for the
// in-order pipeline control path.
package my_pkg;

    typedef enum logic [1:0] {
        DOADD    = 2'd0,
        TAKE4BIT = 2'd1,
        TAKE3BIT = 2'd2,
        BRANCH   = 2'd3
    } alu_op_e;

    typedef struct packed {
        logic [1:0] alu_src;
        alu_op_e    alu_op;
        logic       add_to_pc;
        logic       branch;
        logic       jump;
    } EX_ctrl;

    // cs is the active-low memory chip select
    typedef struct packed {
        logic mem_read;
        logic cs;
    } M_ctrl;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic pc_to_reg;
    } WB_ctrl;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam EX_ctrl EX_BUBBLE = '{alu_src: 2'b00, alu_op: DOADD,
                                    add_to_pc: 1'b0, branch: 1'b0, jump: 1'b0};
    localparam M_ctrl  M_BUBBLE  = '{mem_read: 1'b0, cs: 1'b1};
    localparam WB_ctrl WB_BUBBLE = '{reg_write: 1'b0, mem_to_reg: 1'b0, pc_to_reg: 1'b0};

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: produces the three control bundles, which
// source registers the instruction reads, and an undecoded-opcode flag.
module ctrl_decode
    import my_pkg::*;
(
    input  logic [6:0] opcode_i,
    output EX_ctrl     ex_o,
    output M_ctrl      m_o,
    output WB_ctrl     wb_o,
    output logic       use_rs1_o,
    output logic       use_rs2_o,
    output logic       illegal_o
);

    always_comb begin
        ex_o      = EX_BUBBLE;
        m_o       = M_BUBBLE;
        wb_o      = WB_BUBBLE;
        use_rs1_o = 1'b0;
        use_rs2_o = 1'b0;
        illegal_o = 1'b0;
        case (opcode_i)
            OP_LUI: begin
                wb_o.reg_write = 1'b1;
                ex_o.alu_src   = 2'b10;
            end
            OP_AUIPC: begin
                wb_o.reg_write = 1'b1;
                ex_o.alu_src   = 2'b11;
            end
            OP_STORE: begin
                ex_o.alu_src = 2'b10;
                m_o.cs       = 1'b0;
                use_rs1_o    = 1'b1;
                use_rs2_o    = 1'b1;
            end
            OP_RTYPE: begin
                wb_o.reg_write = 1'b1;
                ex_o.alu_op    = TAKE4BIT;
                use_rs1_o      = 1'b1;
                use_rs2_o      = 1'b1;
            end
            OP_ITYPE: begin
                wb_o.reg_write = 1'b1;
                ex_o.alu_src   = 2'b10;
                ex_o.alu_op    = TAKE3BIT;
                use_rs1_o      = 1'b1;
            end
            OP_LOAD: begin
                wb_o.reg_write  = 1'b1;
                wb_o.mem_to_reg = 1'b1;
                m_o.mem_read    = 1'b1;
                m_o.cs          = 1'b0;
                ex_o.alu_src    = 2'b10;
                use_rs1_o       = 1'b1;
            end
            OP_JALR: begin
                wb_o.reg_write = 1'b1;
                wb_o.pc_to_reg = 1'b1;
                ex_o.add_to_pc = 1'b1;
                ex_o.jump      = 1'b1;
                ex_o.alu_src   = 2'b10;
                use_rs1_o      = 1'b1;
            end
            OP_JAL: begin
                wb_o.reg_write = 1'b1;
                wb_o.pc_to_reg = 1'b1;
                ex_o.jump      = 1'b1;
            end
            OP_BRANCH: begin
                ex_o.branch = 1'b1;
                ex_o.alu_op = BRANCH;
                use_rs1_o   = 1'b1;
                use_rs2_o   = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX, EX/MEM and MEM/WB control registers with freeze, flush and
// load-use interlock handling around the ctrl_decode decoder.
module ctrl_pipe
    import my_pkg::*;
#(
    parameter int unsigned REG_ADDR_W      = 5,
    parameter bit          LOAD_USE_DETECT = 1'b1,
    parameter bit          ILLEGAL_AS_NOP  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_id,
    input  logic [6:0]            opcode_id,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  logic [REG_ADDR_W-1:0] rd_id,
    input  logic                  stall_i,
    input  logic                  flush_i,
    output EX_ctrl                ex_ctrl_o,
    output M_ctrl                 mem_ctrl_o,
    output WB_ctrl                wb_ctrl_o,
    output logic [REG_ADDR_W-1:0] rd_ex_o,
    output logic [REG_ADDR_W-1:0] rd_mem_o,
    output logic [REG_ADDR_W-1:0] rd_wb_o,
    output logic                  valid_ex_o,
    output logic                  valid_mem_o,
    output logic                  valid_wb_o,
    output logic                  hazard_stall_o,
    output logic                  illegal_o
);

    EX_ctrl dec_ex;
    M_ctrl  dec_m;
    WB_ctrl dec_wb;
    logic   dec_use_rs1, dec_use_rs2, dec_illegal;

    ctrl_decode u_decode (
        .opcode_i  (opcode_id),
        .ex_o      (dec_ex),
        .m_o       (dec_m),
        .wb_o      (dec_wb),
        .use_rs1_o (dec_use_rs1),
        .use_rs2_o (dec_use_rs2),
        .illegal_o (dec_illegal)
    );

    EX_ctrl                idex_ex_q, idex_ex_d;
    M_ctrl                 idex_m_q, idex_m_d;
    WB_ctrl                idex_wb_q, idex_wb_d;
    logic [REG_ADDR_W-1:0] idex_rd_q, idex_rd_d;
    logic                  idex_vld_q, idex_vld_d;
    M_ctrl                 exmem_m_q, exmem_m_d;
    WB_ctrl                exmem_wb_q, exmem_wb_d;
    logic [REG_ADDR_W-1:0] exmem_rd_q, exmem_rd_d;
    logic                  exmem_vld_q, exmem_vld_d;
    WB_ctrl                memwb_wb_q, memwb_wb_d;
    logic [REG_ADDR_W-1:0] memwb_rd_q, memwb_rd_d;
    logic                  memwb_vld_q, memwb_vld_d;

    logic rs_match, hazard, kill_id;

    always_comb begin
        rs_match = (dec_use_rs1 && (rs1_id == idex_rd_q)) ||
                   (dec_use_rs2 && (rs2_id == idex_rd_q));
        hazard   = LOAD_USE_DETECT && valid_id && idex_vld_q && idex_m_q.mem_read &&
                   (idex_rd_q != '0) && rs_match;
        kill_id  = flush_i || hazard || !valid_id || (dec_illegal && ILLEGAL_AS_NOP);
    end

    always_comb begin
        idex_ex_d   = idex_ex_q;
        idex_m_d    = idex_m_q;
        idex_wb_d   = idex_wb_q;
        idex_rd_d   = idex_rd_q;
        idex_vld_d  = idex_vld_q;
        exmem_m_d   = exmem_m_q;
        exmem_wb_d  = exmem_wb_q;
        exmem_rd_d  = exmem_rd_q;
        exmem_vld_d = exmem_vld_q;
        memwb_wb_d  = memwb_wb_q;
        memwb_rd_d  = memwb_rd_q;
        memwb_vld_d = memwb_vld_q;
        if (!stall_i) begin
            exmem_m_d   = idex_m_q;
            exmem_wb_d  = idex_wb_q;
            exmem_rd_d  = idex_rd_q;
            exmem_vld_d = idex_vld_q;
            memwb_wb_d  = exmem_wb_q;
            memwb_rd_d  = exmem_rd_q;
            memwb_vld_d = exmem_vld_q;
            idex_ex_d   = dec_ex;
            idex_m_d    = dec_m;
            idex_wb_d   = dec_wb;
            idex_rd_d   = rd_id;
            idex_vld_d  = 1'b1;
        end
        // A flush during a freeze still kills the ID/EX slot
        if (flush_i || (!stall_i && kill_id)) begin
            idex_ex_d  = EX_BUBBLE;
            idex_m_d   = M_BUBBLE;
            idex_wb_d  = WB_BUBBLE;
            idex_rd_d  = '0;
            idex_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_ex_q   <= EX_BUBBLE;
            idex_m_q    <= M_BUBBLE;
            idex_wb_q   <= WB_BUBBLE;
            idex_rd_q   <= '0;
            idex_vld_q  <= 1'b0;
            exmem_m_q   <= M_BUBBLE;
            exmem_wb_q  <= WB_BUBBLE;
            exmem_rd_q  <= '0;
            exmem_vld_q <= 1'b0;
            memwb_wb_q  <= WB_BUBBLE;
            memwb_rd_q  <= '0;
            memwb_vld_q <= 1'b0;
        end else begin
            idex_ex_q   <= idex_ex_d;
            idex_m_q    <= idex_m_d;
            idex_wb_q   <= idex_wb_d;
            idex_rd_q   <= idex_rd_d;
            idex_vld_q  <= idex_vld_d;
            exmem_m_q   <= exmem_m_d;
            exmem_wb_q  <= exmem_wb_d;
            exmem_rd_q  <= exmem_rd_d;
            exmem_vld_q <= exmem_vld_d;
            memwb_wb_q  <= memwb_wb_d;
            memwb_rd_q  <= memwb_rd_d;
            memwb_vld_q <= memwb_vld_d;
        end
    end

    assign ex_ctrl_o      = idex_ex_q;
    assign mem_ctrl_o     = exmem_m_q;
    assign wb_ctrl_o      = memwb_wb_q;
    assign rd_ex_o        = idex_rd_q;
    assign rd_mem_o       = exmem_rd_q;
    assign rd_wb_o        = memwb_rd_q;
    assign valid_ex_o     = idex_vld_q;
    assign valid_mem_o    = exmem_vld_q;
    assign valid_wb_o     = memwb_vld_q;
    assign hazard_stall_o = hazard;
    assign illegal_o      = valid_id && dec_illegal;

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-index width.
REQ-002 SHALL have parameter LOAD_USE_DETECT, default 1, enables load-use hazard stall (0 = hazard_stall_o tied 0).
REQ-003 SHALL have parameter ILLEGAL_AS_NOP, default 1, undecoded opcode enters pipe as bubble (0 = as default bundle with valid 1).
REQ-004 Ports (one clock; reset is synchronous and active-high):
  clk  in  1  sole clock, rising edge
  rst  in  1  synchronous active-high reset
  valid_id  in  1  ID-stage instruction valid
  opcode_id  in  7  ID-stage opcode [6:0]
  rs1_id, rs2_id, rd_id  in  REG_ADDR_W  ID-stage register indices
  stall_i  in  1  global freeze (e.g. memory wait)
  flush_i  in  1  kill ID-stage instruction (branch/jump taken)
  ex_ctrl_o  out  EX_ctrl  ID/EX control bundle
  mem_ctrl_o  out  M_ctrl  EX/MEM control bundle
  wb_ctrl_o  out  WB_ctrl  MEM/WB control bundle
  rd_ex_o, rd_mem_o, rd_wb_o  out  REG_ADDR_W  destination index per stage
  valid_ex_o, valid_mem_o, valid_wb_o  out  1  stage holds real instruction
  hazard_stall_o  out  1  combinational: hold PC and IF/ID
  illegal_o  out  1  combinational: valid_id with undecoded opcode

Function
REQ-005 Decode default bundle: RegWrite/PCtoReg/MemtoReg/MemRead/branch/jump/AddtoPC=0, CS=1 (inactive), ALUsrc=00, ALUop=DOADD.
REQ-006 Decode overrides: 0110111 RegWrite,ALUsrc=10; 0010111 RegWrite,ALUsrc=11; 0100011 ALUsrc=10,CS=0; 0110011 RegWrite,ALUop=TAKE4BIT; 0010011 RegWrite,ALUsrc=10,ALUop=TAKE3BIT; 0000011 RegWrite,MemtoReg,MemRead,CS=0,ALUsrc=10; 1100111 RegWrite,PCtoReg,AddtoPC,jump,ALUsrc=10; 1101111 RegWrite,PCtoReg,jump; 1100011 branch,ALUop=BRANCH.
REQ-007 Bubble = default bundle, valid 0, rd 0; any bundle with valid 0 SHALL equal the bubble.
REQ-008 Pipeline: ID/EX captures decode, EX/MEM captures ID/EX, MEM/WB captures EX/MEM on each clk edge; latency opcode_id -> ex_ctrl_o 1 cycle, -> wb_ctrl_o 3 cycles.
REQ-009 EX/MEM holds M and WB fields only; MEM/WB holds WB fields only.
REQ-010 rs1 used by 0100011,0110011,0010011,0000011,1100111,1100011; rs2 used by 0100011,0110011,1100011.
REQ-011 hazard_stall_o=1 when LOAD_USE_DETECT=1, valid_id, valid_ex_o, ID/EX MemRead=1, rd_ex_o!=0, and rd_ex_o equals a used rs1_id/rs2_id.
REQ-012 Per-edge priority: rst > stall_i > flush_i > hazard_stall_o > normal advance.
REQ-013 stall_i=1: all three stages hold; exception: flush_i=1 simultaneously loads bubble into ID/EX, other stages hold.
REQ-014 flush_i=1 (stall_i=0): ID/EX loads bubble, EX/MEM and MEM/WB advance.
REQ-015 hazard_stall_o=1 (no stall_i/flush_i): ID/EX loads bubble, EX/MEM and MEM/WB advance; ID instruction re-presented next cycle.
REQ-016 valid_id=0: ID/EX loads bubble; hazard_stall_o and illegal_o SHALL be 0.
REQ-017 Illegal opcode: illegal_o=1; ID/EX loads bubble if ILLEGAL_AS_NOP=1.
REQ-018 rd_id=0 with RegWrite=1 SHALL propagate unchanged (x0 masking is downstream).

Reset
REQ-019 rst=1 at clk edge: all three stages SHALL load bubble; all valid_*_o=0, rd_*_o=0, bundles at default values; next cycle outputs per REQ-005.
REQ-020 rst SHALL override stall_i and flush_i; reset mid-stall discards held contents.

Structure
REQ-021 EX_ctrl, M_ctrl, WB_ctrl, ALUop enum, opcode localparams and bubble constants SHALL reside in my_pkg.
REQ-022 Decode SHALL be a combinational sub-module ctrl_decode (opcode in; bundles, rs1/rs2-used, illegal out); ctrl_pipe owns registers and hazard logic.

Verification
REQ-023 LOAD (0000011) at cycle 0 -> ex_ctrl_o ALUsrc=10 cycle 1; mem_ctrl_o MemRead=1,CS=0 cycle 2; wb_ctrl_o RegWrite=1,MemtoReg=1 cycle 3.
REQ-024 LOAD rd=5 then R-type rs2=5 -> hazard_stall_o=1 one cycle, one bubble in EX, R-type enters EX next cycle; LOAD_USE_DETECT=0 -> never asserted.
REQ-025 stall_i=1 for 3 cycles with three instructions in flight -> all outputs constant; released -> resume in order.
REQ-026 flush_i with stall_i both 1 on JAL in ID -> ID/EX bubble, EX/MEM and MEM/WB unchanged.
REQ-027 opcode 1111111 valid -> illegal_o=1, ex_ctrl_o default, valid_ex_o=0 next cycle.
REQ-028 rst mid-stream with full pipe -> next cycle all valid_*_o=0, CS=1, ALUop=DOADD.
